// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem request, presents one instruction at a time to decode.
// Redirects that land while a fetch is in flight are parked in pending until that response drains.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus8
);

  typedef enum logic [1:0] {FETCH, OUT, DROP} state_t;

  state_t      state_q, state_d;
  logic        active_q, active_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // active_q keeps imem_req low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      pending_q <= 32'h0;
      instr_q   <= 32'h0;
      pc_out_q  <= 32'h0;
    end else begin
      pc_q      <= pc_d;
      pending_q <= pending_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = 1'b1;
    case (state_q)
      FETCH: begin
        if (imem_ack && !redirect) state_d = OUT;
        else if (!imem_ack && redirect) state_d = DROP;
      end
      OUT: begin
        if (redirect || !stall) state_d = FETCH;
      end
      DROP: begin
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    pending_d = pending_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    case (state_q)
      FETCH: begin
        if (imem_ack && !redirect) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          pc_d     = pc_q + 32'd4;
        end else if (imem_ack && redirect) begin
          pc_d = redirect_tgt;
        end else if (redirect) begin
          pending_d = redirect_tgt;
        end
      end
      OUT: begin
        if (redirect) pc_d = redirect_tgt;
      end
      DROP: begin
        // A redirect in the ack cycle is newer than anything already parked.
        if (redirect) pending_d = redirect_tgt;
        if (imem_ack) pc_d = redirect ? redirect_tgt : pending_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    imem_req    = active_q && (state_q != OUT);
    imem_addr   = pc_q;
    instr_valid = (state_q == OUT);
    instr       = instr_q;
    pc_out      = pc_out_q;
    pc_plus8    = pc_out_q + 32'd8;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a latency-programmable memory model answers fetches with
// rdata = addr | 0xE0000000, and a monitor pops expected instructions as instr_valid rises.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus8;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_valid(instr_valid),
    .pc_out(pc_out), .pc_plus8(pc_plus8)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   mem_lat = 1;
  bit   mem_en = 1;
  int   mem_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.instr = pc | 32'hE000_0000;
    e.pc    = pc;
    sb_q.push_back(e);
  endtask

  // Memory: acks once a request has been seen for more than mem_lat negedges.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset || !mem_en || imem_ack) begin
        imem_ack = 1'b0;
        mem_cnt  = 0;
      end else if (imem_req) begin
        mem_cnt++;
        if (mem_cnt > mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr | 32'hE000_0000;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Monitor: a rising instr_valid pops the next expectation; held cycles recheck it.
  exp_t        cur;
  bit          have_cur = 0;
  bit          was_v = 0;
  logic [31:0] exp_p8;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (instr_valid) begin
        if (!was_v) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            have_cur = 0;
            $display("FAIL unexpected_instr: got pc_out=%h instr=%h expected none", pc_out, instr);
          end else begin
            cur = sb_q.pop_front();
            have_cur = 1;
          end
        end
        if (have_cur) begin
          exp_p8 = cur.pc + 32'd8;
          chk("instr", instr, cur.instr);
          chk("pc_out", pc_out, cur.pc);
          chk("pc_plus8", pc_plus8, exp_p8);
        end
      end
      was_v = instr_valid;
    end
  end

  task automatic wait_valid_pc(input logic [31:0] pc, input string nm);
    bit hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (instr_valid && pc_out == pc) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: got no instr_valid at pc_out=%h within 60 cycles", nm, pc);
    end
  endtask

  task automatic wait_addr_change(input logic [31:0] old, input string nm);
    bit hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      if (imem_addr != old) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: got imem_addr stuck at %h expected a change within 30 cycles", nm, old);
    end
  endtask

  task automatic wait_req(input string nm);
    bit hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      if (imem_req) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: got imem_req=0 expected 1 within 30 cycles", nm);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    #1 reset = 1'b0;
    #2;
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_pc_plus8", pc_plus8, 32'h8);
    @(posedge clk); #1;
    chk("rst_hold_req", {31'b0, imem_req}, 32'd0);

    // Streaming fetch, then a 4-cycle stall on 0x10.
    push_exp(32'h00); push_exp(32'h04); push_exp(32'h08);
    push_exp(32'h0C); push_exp(32'h10);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    wait_valid_pc(32'h10, "reach_0x10");
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_pc_out", pc_out, 32'h10);
    end
    stall   = 1'b0;
    mem_lat = 3;
    @(negedge clk);
    chk("after_stall_req", {31'b0, imem_req}, 32'd1);
    chk("after_stall_addr", imem_addr, 32'h14);

    // Redirect while the 0x14 fetch is in flight: its data must be dropped.
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    @(negedge clk);
    redirect = 1'b0;
    chk("drop_addr_held", imem_addr, 32'h14);
    chk("drop_req_held", {31'b0, imem_req}, 32'd1);
    wait_addr_change(32'h14, "drop_drain");
    chk("drop_next_addr", imem_addr, 32'h100);
    mem_lat = 1;
    push_exp(32'h100);

    // Redirect beats stall in OUT.
    wait_valid_pc(32'h100, "reach_0x100");
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    mem_lat     = 3;
    @(negedge clk);
    stall = 1'b0;
    chk("redir_out_valid", {31'b0, instr_valid}, 32'd0);
    chk("redir_out_addr", imem_addr, 32'h40);
    chk("redir_out_req", {31'b0, imem_req}, 32'd1);

    // Two redirects while draining: the later one wins.
    redirect_pc = 32'h80;
    @(negedge clk);
    redirect_pc = 32'hC0;
    @(negedge clk);
    redirect = 1'b0;
    chk("drop2_addr_held", imem_addr, 32'h40);
    wait_addr_change(32'h40, "drop2_drain");
    chk("drop2_next_addr", imem_addr, 32'hC0);
    mem_lat = 1;
    push_exp(32'hC0);

    // Redirect to the top word: pc_plus8 and pc+4 both wrap.
    wait_valid_pc(32'hC0, "reach_0xC0");
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid_pc(32'h0, "wrap_to_zero");

    // Asynchronous reset in the middle of the 0x4 fetch.
    wait_req("req_before_reset");
    #2 reset = 1'b0;
    #1;
    chk("async_req", {31'b0, imem_req}, 32'd0);
    chk("async_valid", {31'b0, instr_valid}, 32'd0);
    chk("async_instr", instr, 32'h0);
    chk("async_pc_out", pc_out, 32'h0);
    @(posedge clk); #1;
    chk("async_hold_req", {31'b0, imem_req}, 32'd0);
    push_exp(32'h0);
    push_exp(32'h4);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("rerelease_req", {31'b0, imem_req}, 32'd1);
    chk("rerelease_addr", imem_addr, 32'h0);
    wait_valid_pc(32'h4, "after_reset_0x4");
    mem_en = 1'b0;
    repeat (10) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, giving the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_req  output  1  instruction-memory request.
REQ-005 SHALL have port imem_addr  output  32  fetch address, word aligned.
REQ-006 SHALL have port imem_ack  input  1  memory response strobe, imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port stall  input  1  decode stage cannot accept the presented instruction.
REQ-009 SHALL have port redirect  input  1  taken branch or PC write (PCS path) this cycle.
REQ-010 SHALL have port redirect_pc  input  32  target address for redirect.
REQ-011 SHALL have port instr  output  32  instruction presented to the decoder (Op = instr[27:26], Funct = instr[25:20], Rd = instr[15:12]).
REQ-012 SHALL have port instr_valid  output  1  instr, pc_out and pc_plus8 are valid.
REQ-013 SHALL have ports pc_out  output  32  address of instr, and pc_plus8  output  32  pc_out + 8 (PC read value).

Function
REQ-014 SHALL implement FSM states FETCH, OUT, DROP, plus a 32-bit fetch pointer pc and a 32-bit pending-target register.
REQ-015 SHALL drive imem_req=1 in FETCH and DROP and 0 in OUT; imem_addr SHALL equal pc and stay stable until imem_ack.
REQ-016 FETCH, imem_ack=1, redirect=0: SHALL load instr<=imem_rdata, pc_out<=pc, set instr_valid<=1, set pc<=pc+4 (mod 2^32), and go to OUT.
REQ-017 FETCH, imem_ack=1, redirect=1: SHALL discard imem_rdata, set pc<=redirect_pc, and stay in FETCH.
REQ-018 FETCH, imem_ack=0, redirect=1: SHALL capture redirect_pc into pending and go to DROP; imem_addr SHALL keep the old pc.
REQ-019 DROP: SHALL hold the request and discard data on imem_ack; on ack SHALL set pc<=pending and go to FETCH. A redirect in DROP SHALL overwrite pending, with the latest target winning; a redirect coincident with ack SHALL use redirect_pc directly.
REQ-020 OUT, redirect=1: SHALL clear instr_valid, set pc<=redirect_pc, and go to FETCH; redirect SHALL take priority over stall.
REQ-021 OUT, redirect=0, stall=1: SHALL hold instr, pc_out and instr_valid unchanged.
REQ-022 OUT, redirect=0, stall=0: the instruction SHALL be consumed; instr_valid<=0 and go to FETCH.
REQ-023 instr_valid SHALL be 1 only in OUT; one fetch SHALL be outstanding at most; peak throughput SHALL be one instruction per 3 cycles with 1-cycle memory.
REQ-024 Bits [1:0] of redirect_pc SHALL be forced to 0 when loaded into pc or pending.
REQ-025 imem_ack in OUT SHALL be ignored.
REQ-026 pc_plus8 SHALL be the combinational pc_out+8, wrapping mod 2^32.

Reset
REQ-027 While reset=0: imem_req=0, instr_valid=0, instr=0, pc_out=0, pc=RESET_PC, pending=0, state=FETCH; this SHALL apply immediately, independent of clk.
REQ-028 First rising edge after reset deasserts: imem_req=1, imem_addr=RESET_PC.
REQ-029 Reset asserted mid-fetch SHALL drop imem_req asynchronously; any later ack of the aborted request arriving before the first post-reset ack is the memory's responsibility and SHALL be treated as a normal ack.

Verification
REQ-030 Reset release, memory acks every request after 1 cycle with rdata=addr|0xE0000000 -> instr_valid pulses with pc_out 0,4,8; pc_plus8=8,12,16.
REQ-031 stall=1 for 4 cycles while instr_valid=1 at pc_out=0x10 -> instr and pc_out held, imem_req=0; after stall drops, next imem_addr=0x14.
REQ-032 redirect=1, redirect_pc=0x103 in FETCH with ack delayed 3 cycles -> imem_addr stays old pc, data discarded, next imem_addr=0x100, no instr_valid for the dropped word.
REQ-033 redirect=1 with stall=1 in OUT, redirect_pc=0x40 -> instr_valid=0 next cycle, imem_addr=0x40.
REQ-034 Two redirects in DROP (0x80 then 0xC0) -> next fetch at 0xC0.
REQ-035 reset asserted mid-cycle while imem_req=1 -> imem_req and instr_valid fall before the next clk edge, and the first fetch after release is RESET_PC.
